// File: rtl/wb_pkg.sv
// wb_pkg: shared encodings, state enum and trap cause codes for the writeback stage
package wb_pkg;

    localparam logic [1:0] WSEL_ALU  = 2'b00;
    localparam logic [1:0] WSEL_LOAD = 2'b01;
    localparam logic [1:0] WSEL_CSR  = 2'b10;
    localparam logic [1:0] WSEL_PC   = 2'b11;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2,
        ST_WFI  = 2'd3
    } wb_state_e;

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_INSTR_FAULT      = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;
    localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

endpackage

// File: rtl/load_align.sv
// load_align: shifts the raw bus word to the addressed byte lane and extends it to 32 bits
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data_out
);

    logic [31:0] shifted;

    // byte-lane shift, then truncate and extend; the unused size code reads as zero
    always_comb begin
        shifted  = data_in >> {offset, 3'b000};
        data_out = (size == SIZE_BYTE) ? {{24{sign_ext & shifted[7]}}, shifted[7:0]} :
                   (size == SIZE_HALF) ? {{16{sign_ext & shifted[15]}}, shifted[15:0]} :
                   (size == SIZE_WORD) ? shifted : 32'd0;
    end

endmodule

// File: rtl/writeback.sv
// writeback: final pipeline stage; register/CSR writes plus trap, mret and wfi sequencing.
// Define WB_INSTRET_EN to add the 64-bit retired-instruction counter and its instret port.
module writeback
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic [31:0] alu_data_in,
    input  logic [31:0] csr_data_in,
    input  logic [31:0] load_data_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_signed_in,
    input  logic [1:0]  write_select_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [11:0] csr_addr_in,
    input  logic        csr_write_in,
    input  logic        mret_in,
    input  logic        wfi_in,
    input  logic        valid_in,
    input  logic        exception_in,
    input  logic [3:0]  ecause_in,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    input  logic        interrupt_pending,
    output logic        reg_we,
    output logic [4:0]  reg_waddr,
    output logic [31:0] reg_wdata,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        trap_take,
    output logic [31:0] trap_mepc,
    output logic [3:0]  trap_mcause,
    output logic        mret_take,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        stall_out
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0] instret
`endif
);

    wb_state_e   state_q, state_d;
    logic [31:0] mepc_q, mepc_d;
    logic [3:0]  mcause_q, mcause_d;
    logic [31:0] load_data;
    logic        accept, retire, take_exc;

    load_align u_load_align (
        .data_in  (load_data_in),
        .offset   (alu_data_in[1:0]),
        .size     (load_size_in),
        .sign_ext (load_signed_in),
        .data_out (load_data)
    );

    // acceptance, write ports, trap/return outputs and next state; rst_n gating keeps every output quiet in reset
    always_comb begin
        accept      = rst_n && valid_in && (state_q == ST_RUN);
        take_exc    = accept && exception_in;
        retire      = accept && !exception_in;
        reg_we      = retire && (rd_addr_in != 5'd0);
        reg_waddr   = reg_we ? rd_addr_in : 5'd0;
        reg_wdata   = !reg_we ? 32'd0 :
                      (write_select_in == WSEL_ALU)  ? alu_data_in :
                      (write_select_in == WSEL_LOAD) ? load_data :
                      (write_select_in == WSEL_CSR)  ? csr_data_in : next_pc_in;
        csr_we      = retire && csr_write_in;
        csr_waddr   = csr_we ? csr_addr_in : 12'd0;
        csr_wdata   = csr_we ? alu_data_in : 32'd0;
        trap_take   = (state_q == ST_TRAP);
        trap_mepc   = trap_take ? mepc_q : 32'd0;
        trap_mcause = trap_take ? mcause_q : 4'd0;
        mret_take   = (state_q == ST_RET);
        redirect    = trap_take || mret_take;
        redirect_pc = trap_take ? mtvec_in : mret_take ? mepc_in : 32'd0;
        flush       = redirect || take_exc || (retire && mret_in);
        stall_out   = (state_q == ST_WFI) && !interrupt_pending;
        mepc_d      = take_exc ? pc_in : mepc_q;
        mcause_d    = take_exc ? ecause_in : mcause_q;
        state_d     = take_exc ? ST_TRAP :
                      (retire && mret_in) ? ST_RET :
                      (retire && wfi_in) ? ST_WFI :
                      (state_q == ST_WFI && !interrupt_pending) ? ST_WFI : ST_RUN;
    end

    // state and captured trap context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            mepc_q   <= 32'd0;
            mcause_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // retire counter; natural 64-bit overflow gives the wrap to zero
    always_comb begin
        instret_d = retire ? instret_q + 64'd1 : instret_q;
        instret   = instret_q;
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) instret_q <= 64'd0;
        else        instret_q <= instret_d;
    end
`endif

endmodule
